// File: rtl/seq_mag_compare.sv
// Sequential magnitude comparator: walks operands one SLICE-bit slice per clock from the MSB
// and stops at the first differing slice. Unsigned or two's-complement, valid/ready on both sides.
module seq_mag_compare #(
   parameter  int WIDTH  = 8,
   parameter  int SLICE  = 2,
   localparam int NSLICE = WIDTH / SLICE,
   localparam int CW     = $clog2(NSLICE) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic             ge,
   output logic [CW-1:0]    slices_used
);

   localparam int               KW       = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0]    K_TOP    = KW'(NSLICE - 1);
   localparam logic [CW-1:0]    NS_CW    = CW'(NSLICE);
   localparam logic [SLICE-1:0] MSB_FLIP = SLICE'(1) << (SLICE - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_sgn;
   logic [KW-1:0]    r_k;
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;
   logic [CW-1:0]    r_used;
   logic [SLICE-1:0] w_sa;
   logic [SLICE-1:0] w_sb;
   logic             w_diff;
   logic             w_last;

   // Flipping the sign bit of the top slice maps two's-complement order onto unsigned order.
   always_comb begin
      w_sa = SLICE'(r_a >> (r_k * SLICE));
      w_sb = SLICE'(r_b >> (r_k * SLICE));
      if (r_sgn && (r_k == K_TOP)) begin
         w_sa = w_sa ^ MSB_FLIP;
         w_sb = w_sb ^ MSB_FLIP;
      end
   end

   assign w_diff = (w_sa != w_sb);
   assign w_last = (r_k == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)          w_state_nxt = SCAN;
         SCAN:    if (w_diff || w_last)  w_state_nxt = DONE;
         DONE:    if (out_ready)         w_state_nxt = IDLE;
         default:                        w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_sgn  <= 1'b0;
         r_k    <= '0;
         r_gt   <= 1'b0;
         r_eq   <= 1'b0;
         r_lt   <= 1'b0;
         r_used <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_sgn <= signed_mode;
                  r_k   <= K_TOP;
               end
            end
            SCAN: begin
               if (w_diff) begin
                  r_gt   <= (w_sa > w_sb);
                  r_lt   <= (w_sa < w_sb);
                  r_eq   <= 1'b0;
                  r_used <= NS_CW - CW'(r_k);
               end else if (w_last) begin
                  r_gt   <= 1'b0;
                  r_lt   <= 1'b0;
                  r_eq   <= 1'b1;
                  r_used <= NS_CW;
               end else begin
                  r_k <= r_k - KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready    = (r_state == IDLE);
   assign out_valid   = (r_state == DONE);
   assign gt          = r_gt;
   assign eq          = r_eq;
   assign lt          = r_lt;
   assign ge          = r_gt | r_eq;
   assign slices_used = r_used;

endmodule

// File: tb/tb_seq_mag_compare.sv
// Directed and randomised checks of seq_mag_compare at WIDTH=8/SLICE=2 and WIDTH=16/SLICE=4.
module tb_seq_mag_compare;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        rst8_n = 1'b1;
   logic        iv8 = 1'b0, ir8, sm8 = 1'b0, ov8, or8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        gt8, eq8, lt8, ge8;
   logic [2:0]  used8;

   logic        rst16_n = 1'b1;
   logic        iv16 = 1'b0, ir16, sm16 = 1'b0, ov16, or16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        gt16, eq16, lt16, ge16;
   logic [2:0]  used16;

   seq_mag_compare #(.WIDTH(8), .SLICE(2)) dut8 (
      .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .gt(gt8), .eq(eq8),
      .lt(lt8), .ge(ge8), .slices_used(used8)
   );

   seq_mag_compare #(.WIDTH(16), .SLICE(4)) dut16 (
      .clk(clk), .rst_n(rst16_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .gt(gt16), .eq(eq16),
      .lt(lt16), .ge(ge16), .slices_used(used16)
   );

   // Flags packed as {gt,eq,lt,ge}; lat counts edges after the accept edge until out_valid.
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm,
                       output logic [3:0] flags, output logic [2:0] used, output int lat);
      int guard = 0;
      while (!ir8 && guard < 50) begin @(posedge clk); #1; guard++; end
      a8 = ta; b8 = tb; sm8 = tsm; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0; a8 = ~ta; b8 = 8'h5A; sm8 = ~tsm;
      lat = 0;
      while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
      flags = {gt8, eq8, lt8, ge8};
      used  = used8;
   endtask

   task automatic release8();
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
   endtask

   task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tsm,
                        output logic [3:0] flags, output logic [2:0] used, output int lat);
      int guard = 0;
      while (!ir16 && guard < 50) begin @(posedge clk); #1; guard++; end
      a16 = ta; b16 = tb; sm16 = tsm; iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0; a16 = ~ta; b16 = 16'hC3C3; sm16 = ~tsm;
      lat = 0;
      while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
      flags = {gt16, eq16, lt16, ge16};
      used  = used16;
   endtask

   task automatic release16();
      or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      rst8_n = 1'b0; rst16_n = 1'b0;
      #1;
      checks++;
      if ({ov8, ir8, gt8, eq8, lt8, ge8, used8} !== 9'b01_0000_000) begin
         failures++;
         $display("FAIL reset8 got ov/ir/flags/used=%b want 010000000",
                  {ov8, ir8, gt8, eq8, lt8, ge8, used8});
      end
      checks++;
      if ({ov16, ir16, gt16, eq16, lt16, ge16, used16} !== 9'b01_0000_000) begin
         failures++;
         $display("FAIL reset16 got ov/ir/flags/used=%b want 010000000",
                  {ov16, ir16, gt16, eq16, lt16, ge16, used16});
      end
      @(posedge clk); @(posedge clk); #1;
      rst8_n = 1'b1; rst16_n = 1'b1;
   endtask

   task automatic test_early_exit();
      logic [3:0] f; logic [2:0] u; int l;
      run8(8'hC5, 8'h3A, 1'b0, f, u, l);
      checks++;
      if ({f, u, l} !== {4'b1001, 3'd1, 32'd1}) begin
         failures++;
         $display("FAIL early_exit got flags=%b used=%0d lat=%0d want 1001 1 1", f, u, l);
      end
      release8();
   endtask

   task automatic test_equal();
      logic [3:0] f; logic [2:0] u; int l;
      run8(8'hA5, 8'hA5, 1'b0, f, u, l);
      checks++;
      if ({f, u, l} !== {4'b0101, 3'd4, 32'd4}) begin
         failures++;
         $display("FAIL equal got flags=%b used=%0d lat=%0d want 0101 4 4", f, u, l);
      end
      release8();
   endtask

   task automatic test_lsb_decide();
      logic [3:0] f; logic [2:0] u; int l;
      run8(8'hA4, 8'hA6, 1'b0, f, u, l);
      checks++;
      if ({f, u, l} !== {4'b0010, 3'd4, 32'd4}) begin
         failures++;
         $display("FAIL lsb_decide got flags=%b used=%0d lat=%0d want 0010 4 4", f, u, l);
      end
      release8();
   endtask

   task automatic test_signed();
      logic [3:0] f; logic [2:0] u; int l;
      run8(8'h80, 8'h7F, 1'b1, f, u, l);
      checks++;
      if ({f, u, l} !== {4'b0010, 3'd1, 32'd1}) begin
         failures++;
         $display("FAIL signed_80_7f got flags=%b used=%0d lat=%0d want 0010 1 1", f, u, l);
      end
      release8();
      run8(8'h80, 8'h7F, 1'b0, f, u, l);
      checks++;
      if ({f, u, l} !== {4'b1001, 3'd1, 32'd1}) begin
         failures++;
         $display("FAIL unsigned_80_7f got flags=%b used=%0d lat=%0d want 1001 1 1", f, u, l);
      end
      release8();
      run8(8'hFF, 8'h01, 1'b1, f, u, l);
      checks++;
      if ({f, u, l} !== {4'b0010, 3'd1, 32'd1}) begin
         failures++;
         $display("FAIL signed_ff_01 got flags=%b used=%0d lat=%0d want 0010 1 1", f, u, l);
      end
      release8();
      run8(8'hFE, 8'hFF, 1'b1, f, u, l);
      checks++;
      if ({f, u, l} !== {4'b0010, 3'd4, 32'd4}) begin
         failures++;
         $display("FAIL signed_fe_ff got flags=%b used=%0d lat=%0d want 0010 4 4", f, u, l);
      end
      release8();
      run16(16'h8000, 16'h7FFF, 1'b1, f, u, l);
      checks++;
      if ({f, u, l} !== {4'b0010, 3'd1, 32'd1}) begin
         failures++;
         $display("FAIL signed16_8000 got flags=%b used=%0d lat=%0d want 0010 1 1", f, u, l);
      end
      release16();
   endtask

   task automatic test_back_to_back();
      logic [3:0] f; logic [2:0] u; int l;
      run8(8'hC5, 8'h3A, 1'b0, f, u, l);
      for (int i = 0; i < 3; i++) begin
         if (i == 0) begin iv8 = 1'b1; a8 = 8'h00; b8 = 8'hFF; end
         @(posedge clk); #1;
         iv8 = 1'b0;
         checks++;
         if ({ov8, ir8, gt8, eq8, lt8, ge8, used8} !== 9'b10_1001_001) begin
            failures++;
            $display("FAIL backpressure_hold%0d got ov/ir/flags/used=%b want 101001001", i,
                     {ov8, ir8, gt8, eq8, lt8, ge8, used8});
         end
      end
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
      checks++;
      if ({ov8, ir8} !== 2'b01) begin
         failures++;
         $display("FAIL backpressure_release got ov/ir=%b want 01", {ov8, ir8});
      end
      run8(8'h00, 8'hFF, 1'b0, f, u, l);
      checks++;
      if ({f, u, l} !== {4'b0010, 3'd1, 32'd1}) begin
         failures++;
         $display("FAIL next_after_release got flags=%b used=%0d lat=%0d want 0010 1 1", f, u, l);
      end
      release8();
   endtask

   task automatic test_reset_mid();
      logic [3:0] f; logic [2:0] u; int l;
      a8 = 8'hA5; b8 = 8'hA5; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      @(posedge clk); #1;
      rst8_n = 1'b0;
      #1;
      checks++;
      if ({ov8, ir8, gt8, eq8, lt8, ge8, used8} !== 9'b01_0000_000) begin
         failures++;
         $display("FAIL reset_mid8 got ov/ir/flags/used=%b want 010000000",
                  {ov8, ir8, gt8, eq8, lt8, ge8, used8});
      end
      @(posedge clk); #1;
      rst8_n = 1'b1;
      run8(8'h01, 8'h02, 1'b0, f, u, l);
      checks++;
      if ({f, u, l} !== {4'b0010, 3'd4, 32'd4}) begin
         failures++;
         $display("FAIL after_reset8 got flags=%b used=%0d lat=%0d want 0010 4 4", f, u, l);
      end
      release8();

      run16(16'h1234, 16'h0234, 1'b0, f, u, l);
      release16();
      a16 = 16'hA5A5; b16 = 16'hA5A5; iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      @(posedge clk); #1;
      rst16_n = 1'b0;
      #1;
      checks++;
      if ({ov16, ir16, gt16, eq16, lt16, ge16, used16} !== 9'b01_0000_000) begin
         failures++;
         $display("FAIL reset_mid16 got ov/ir/flags/used=%b want 010000000",
                  {ov16, ir16, gt16, eq16, lt16, ge16, used16});
      end
      @(posedge clk); #1;
      rst16_n = 1'b1;
      run16(16'h0001, 16'h0002, 1'b0, f, u, l);
      checks++;
      if ({f, u, l} !== {4'b0010, 3'd4, 32'd4}) begin
         failures++;
         $display("FAIL after_reset16 got flags=%b used=%0d lat=%0d want 0010 4 4", f, u, l);
      end
      release16();
   endtask

   task automatic test_random16();
      logic [15:0] ta, tb, diff;
      logic        tsm;
      logic [3:0]  f, ef;
      logic [2:0]  u, eu;
      int          l;
      for (int n = 0; n < 1000; n++) begin
         ta  = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       tb = ta;
            1:       tb = ta ^ (16'h0001 << $urandom_range(0, 15));
            default: tb = 16'($urandom);
         endcase
         tsm = 1'($urandom_range(0, 1));
         if (ta == tb)                                 ef = 4'b0101;
         else if (tsm && ($signed(ta) > $signed(tb)))  ef = 4'b1001;
         else if (tsm)                                 ef = 4'b0010;
         else if (ta > tb)                             ef = 4'b1001;
         else                                          ef = 4'b0010;
         diff = ta ^ tb;
         eu = 3'd4;
         for (int s = 0; s < 4; s++)
            if (diff[s*4 +: 4] != 4'h0) eu = 3'(4 - s);
         run16(ta, tb, tsm, f, u, l);
         checks++;
         if ({f, u, l} !== {ef, eu, 32'(eu)}) begin
            failures++;
            $display("FAIL random16 a=%h b=%h s=%0d got flags=%b used=%0d lat=%0d want %b %0d %0d",
                     ta, tb, tsm, f, u, l, ef, eu, eu);
         end
         release16();
      end
   endtask

   initial begin
      test_reset();
      test_early_exit();
      test_equal();
      test_lsb_decide();
      test_signed();
      test_back_to_back();
      test_reset_mid();
      test_random16();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
